// File: rtl/vga_timing_ctrl.sv
// VGA raster sequencer: internal pixel strobe, h/v counters, registered sync/blank decode and frame-aligned run/stop.
// Define VGA_FRAME_TICK_EN to generate frame_tick; otherwise frame_tick is tied low.
module vga_timing_ctrl #(
   parameter int unsigned DIV      = 4,
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33
) (
   input  logic       clk,
   input  logic       clr_n,
   input  logic       en,
   output logic       running,
   output logic       pix_en,
   output logic [9:0] px_x,
   output logic [9:0] px_y,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic       frame_tick
);

   localparam int unsigned CNT_W   = 10;
   localparam int unsigned PH_W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(DIV - 1);
   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [PH_W-1:0]  phase_q, phase_d;
   logic [CNT_W-1:0] x_q, x_d;
   logic [CNT_W-1:0] y_q, y_d;
   logic             pix_en_q, pix_en_d;
   logic             running_q, running_d;
   logic             hsync_q, hsync_d;
   logic             vsync_q, vsync_d;
   logic             video_on_q, video_on_d;
   logic             eof_c;

   // Last clk of the last pixel of the frame: the only point a drain may stop.
   assign eof_c = pix_en_q && (x_q == H_LAST) && (y_q == V_LAST);

   // Next state, divider phase, raster counters and decode of the pixel they will hold.
   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      x_d        = x_q;
      y_d        = y_q;
      running_d  = 1'b0;
      pix_en_d   = 1'b0;
      hsync_d    = 1'b1;
      vsync_d    = 1'b1;
      video_on_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (en) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!en) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (en) begin
               state_d = ST_RUN;
            end else if (eof_c) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Phase stays at 0 on the start edge so the first strobe lands DIV clks after en.
      if ((state_q == ST_IDLE) || (state_d == ST_IDLE)) begin
         phase_d = '0;
      end else if (phase_q == PH_LAST) begin
         phase_d = '0;
      end else begin
         phase_d = phase_q + PH_W'(1);
      end

      if (state_d == ST_IDLE) begin
         x_d = '0;
         y_d = '0;
      end else if (pix_en_q) begin
         if (x_q == H_LAST) begin
            x_d = '0;
            y_d = (y_q == V_LAST) ? '0 : y_q + CNT_W'(1);
         end else begin
            x_d = x_q + CNT_W'(1);
         end
      end

      running_d  = (state_d != ST_IDLE);
      pix_en_d   = running_d && (phase_d == PH_LAST);
      hsync_d    = !(running_d && (x_d >= HS_FIRST) && (x_d <= HS_LAST));
      vsync_d    = !(running_d && (y_d >= VS_FIRST) && (y_d <= VS_LAST));
      video_on_d = running_d && (x_d < H_ACT) && (y_d < V_ACT);
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q    <= ST_IDLE;
         phase_q    <= '0;
         x_q        <= '0;
         y_q        <= '0;
         pix_en_q   <= 1'b0;
         running_q  <= 1'b0;
         hsync_q    <= 1'b1;
         vsync_q    <= 1'b1;
         video_on_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         x_q        <= x_d;
         y_q        <= y_d;
         pix_en_q   <= pix_en_d;
         running_q  <= running_d;
         hsync_q    <= hsync_d;
         vsync_q    <= vsync_d;
         video_on_q <= video_on_d;
      end
   end

`ifdef VGA_FRAME_TICK_EN
   logic frame_tick_q, frame_tick_d;

   // Pulse on the step into (0, V_ACTIVE): first blank line of the frame.
   always_comb begin
      frame_tick_d = running_d && pix_en_q && (x_d == '0) && (y_d == V_ACT);
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         frame_tick_q <= 1'b0;
      end else begin
         frame_tick_q <= frame_tick_d;
      end
   end

   assign frame_tick = frame_tick_q;
`else
   assign frame_tick = 1'b0;
`endif

   assign running  = running_q;
   assign pix_en   = pix_en_q;
   assign px_x     = x_q;
   assign px_y     = y_q;
   assign hsync    = hsync_q;
   assign vsync    = vsync_q;
   assign video_on = video_on_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl on a reduced raster; expected outputs come from a clock-count raster model.
module tb_vga_timing_ctrl;

   localparam int unsigned DIV = 4;
   localparam int unsigned HA = 20, HF = 3, HS = 5, HB = 4;
   localparam int unsigned VA = 10, VF = 2, VS = 2, VB = 3;
   localparam int unsigned HT = HA + HF + HS + HB;
   localparam int unsigned VT = VA + VF + VS + VB;
   localparam int unsigned FRAME_PIX = HT * VT;
   localparam int unsigned FRAME_CLK = FRAME_PIX * DIV;
`ifdef VGA_FRAME_TICK_EN
   localparam bit FT_EN = 1'b1;
`else
   localparam bit FT_EN = 1'b0;
`endif
   localparam logic [25:0] RST_VEC = {1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};

   logic       clk = 1'b0;
   logic       clr_n = 1'b0;
   logic       en = 1'b0;
   logic       running, pix_en, hsync, vsync, video_on, frame_tick;
   logic [9:0] px_x, px_y;
   logic [25:0] obs;
   int         n_cmp = 0;
   int         n_fail = 0;

   always #5 clk = ~clk;

   vga_timing_ctrl #(
      .DIV(DIV), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
   ) dut (
      .clk(clk), .clr_n(clr_n), .en(en), .running(running), .pix_en(pix_en),
      .px_x(px_x), .px_y(px_y), .hsync(hsync), .vsync(vsync),
      .video_on(video_on), .frame_tick(frame_tick)
   );

   assign obs = {running, pix_en, px_x, px_y, hsync, vsync, video_on, frame_tick};

   // Reference: clocks elapsed since the run started; the raster position is plain division of that count.
   logic        m_run = 1'b0;
   logic        m_drain = 1'b0;
   int unsigned m_k = 0;

   function automatic logic m_eof();
      return m_run && (m_k % DIV == DIV - 1) && ((m_k / DIV) % FRAME_PIX == FRAME_PIX - 1);
   endfunction

   function automatic logic m_at(input int unsigned x, input int unsigned y);
      return m_run && (m_k % DIV == 0) && ((m_k / DIV) % FRAME_PIX == y * HT + x);
   endfunction

   function automatic logic [25:0] model_vec();
      int unsigned n, x, y;
      logic pe, hs, vs, vid, ft;
      n   = m_k / DIV;
      x   = n % HT;
      y   = (n / HT) % VT;
      pe  = m_run && (m_k % DIV == DIV - 1);
      hs  = !(m_run && x >= HA + HF && x < HA + HF + HS);
      vs  = !(m_run && y >= VA + VF && y < VA + VF + VS);
      vid = m_run && x < HA && y < VA;
      ft  = FT_EN && m_run && x == 0 && y == VA && (m_k % DIV == 0);
      return {m_run, pe, 10'(x), 10'(y), hs, vs, vid, ft};
   endfunction

   always @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         m_run <= 1'b0; m_drain <= 1'b0; m_k <= 0;
      end else if (!m_run) begin
         if (en) begin
            m_run <= 1'b1; m_drain <= 1'b0; m_k <= 0;
         end
      end else if (m_drain && !en && m_eof()) begin
         m_run <= 1'b0; m_drain <= 1'b0; m_k <= 0;
      end else begin
         m_drain <= !en;
         m_k     <= m_k + 1;
      end
   end

   // Stimulus only: reset, release, then request a run on the next edge.
   task automatic restart();
      @(negedge clk); en = 1'b0; clr_n = 1'b0;
      @(negedge clk); clr_n = 1'b1;
      @(negedge clk); en = 1'b1;
   endtask

   // Advance until the model sits on the first clk of pixel (x,y); reports cycles that disagreed with it.
   task automatic run_to(input int unsigned x, input int unsigned y, output bit ok, output int bad, output int idle);
      ok = 1'b0; bad = 0; idle = 0;
      for (int c = 0; c < 2 * FRAME_CLK && !ok; c++) begin
         @(negedge clk);
         if (obs !== model_vec()) bad++;
         if (running !== 1'b1) idle++;
         if (m_at(x, y)) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      en = 1'b0; clr_n = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (obs !== RST_VEC) begin n_fail++; $display("FAIL reset_vec got=%h want=%h", obs, RST_VEC); end
      clr_n = 1'b1;
      repeat (5) @(negedge clk);
      n_cmp++;
      if (obs !== RST_VEC) begin n_fail++; $display("FAIL idle_vec got=%h want=%h", obs, RST_VEC); end
   endtask

   task automatic test_start();
      int first_pe, last_pe, pe_cnt, bad_period;
      first_pe = -1; last_pe = 0; pe_cnt = 0; bad_period = 0;
      en = 1'b1;
      for (int j = 1; j <= int'(HT * DIV) + 8; j++) begin
         @(negedge clk);
         n_cmp++;
         if (obs !== model_vec()) begin n_fail++; $display("FAIL start_vec j=%0d got=%h want=%h", j, obs, model_vec()); end
         if (j == 1) begin
            n_cmp++;
            if (running !== 1'b1 || video_on !== 1'b1 || px_x !== 10'd0 || px_y !== 10'd0)
               begin n_fail++; $display("FAIL start_latency run=%b vid=%b x=%0d y=%0d want 1 1 0 0", running, video_on, px_x, px_y); end
         end
         if (j <= 40 && pix_en === 1'b1) begin
            if (first_pe < 0) first_pe = j;
            else if (j - last_pe != int'(DIV)) bad_period++;
            last_pe = j; pe_cnt++;
         end
         if (j == 40) begin
            n_cmp++;
            if (px_x !== 10'd9 || px_y !== 10'd0) begin n_fail++; $display("FAIL px_after_40 x=%0d y=%0d want 9 0", px_x, px_y); end
         end
         if (j == int'(HT * DIV)) begin
            n_cmp++;
            if (px_x !== 10'(HT - 1) || px_y !== 10'd0) begin n_fail++; $display("FAIL line_end x=%0d y=%0d want %0d 0", px_x, px_y, HT - 1); end
         end
         if (j == int'(HT * DIV) + 1) begin
            n_cmp++;
            if (px_x !== 10'd0 || px_y !== 10'd1) begin n_fail++; $display("FAIL line_wrap x=%0d y=%0d want 0 1", px_x, px_y); end
         end
      end
      n_cmp++;
      if (first_pe != 4) begin n_fail++; $display("FAIL first_pix_en at=%0d want 4", first_pe); end
      n_cmp++;
      if (pe_cnt != 10 || bad_period != 0) begin n_fail++; $display("FAIL pix_en_period cnt=%0d badgaps=%0d want 10 0", pe_cnt, bad_period); end
   endtask

   task automatic test_full_frame();
      int hs_low, vs_low, vid, ft, wrap_at;
      bit zero, prev_zero;
      hs_low = 0; vs_low = 0; vid = 0; ft = 0; wrap_at = -1; prev_zero = 1'b1;
      restart();
      for (int i = 0; i < int'(FRAME_CLK + 2 * DIV); i++) begin
         @(negedge clk);
         n_cmp++;
         if (obs !== model_vec()) begin n_fail++; $display("FAIL frame_vec i=%0d got=%h want=%h", i, obs, model_vec()); end
         if (i < int'(FRAME_CLK)) begin
            if (hsync === 1'b0) hs_low++;
            if (vsync === 1'b0) vs_low++;
            if (video_on === 1'b1) vid++;
            if (frame_tick === 1'b1) ft++;
         end
         zero = (px_x === 10'd0) && (px_y === 10'd0);
         if (zero && !prev_zero && wrap_at < 0) wrap_at = i;
         prev_zero = zero;
      end
      n_cmp++;
      if (hs_low != int'(HS * DIV * VT)) begin n_fail++; $display("FAIL hsync_low_clks got=%0d want=%0d", hs_low, HS * DIV * VT); end
      n_cmp++;
      if (vs_low != int'(VS * HT * DIV)) begin n_fail++; $display("FAIL vsync_low_clks got=%0d want=%0d", vs_low, VS * HT * DIV); end
      n_cmp++;
      if (vid != int'(HA * VA * DIV)) begin n_fail++; $display("FAIL video_on_clks got=%0d want=%0d", vid, HA * VA * DIV); end
      n_cmp++;
      if (ft != int'(FT_EN)) begin n_fail++; $display("FAIL frame_tick_count got=%0d want=%0d", ft, FT_EN); end
      n_cmp++;
      if (wrap_at != int'(FRAME_CLK)) begin n_fail++; $display("FAIL frame_length got=%0d want=%0d", wrap_at, FRAME_CLK); end
   endtask

   task automatic test_drain();
      bit ok, fell, prev_last;
      int bad, idle;
      restart();
      run_to(10, 5, ok, bad, idle);
      n_cmp++;
      if (!ok || bad != 0) begin n_fail++; $display("FAIL drain_align reached=%0d badcycles=%0d want 1 0", ok, bad); end
      en = 1'b0;
      fell = 1'b0; prev_last = 1'b0;
      for (int c = 0; c < int'(FRAME_CLK) + 16 && !fell; c++) begin
         @(negedge clk);
         n_cmp++;
         if (obs !== model_vec()) begin n_fail++; $display("FAIL drain_vec c=%0d got=%h want=%h", c, obs, model_vec()); end
         if (running !== 1'b1) begin
            fell = 1'b1;
            n_cmp++;
            if (obs !== RST_VEC || !prev_last) begin n_fail++; $display("FAIL drain_stop got=%h lastpix=%0d want=%h 1", obs, prev_last, RST_VEC); end
         end else begin
            prev_last = (px_x === 10'(HT - 1)) && (px_y === 10'(VT - 1));
         end
      end
      n_cmp++;
      if (!fell) begin n_fail++; $display("FAIL drain_timeout running=%b want 0", running); end
      repeat (8) @(negedge clk);
      n_cmp++;
      if (obs !== RST_VEC) begin n_fail++; $display("FAIL idle_hold got=%h want=%h", obs, RST_VEC); end
   endtask

   task automatic test_glitch();
      bit ok, saw_origin;
      int bad, idle, drops, jumps;
      int unsigned idx, prev_idx;
      restart();
      run_to(10, 5, ok, bad, idle);
      en = 1'b0;
      n_cmp++;
      if (!ok || bad != 0) begin n_fail++; $display("FAIL glitch_align reached=%0d badcycles=%0d want 1 0", ok, bad); end
      run_to(25, 8, ok, bad, idle);
      en = 1'b1;
      n_cmp++;
      if (!ok || bad != 0 || idle != 0) begin n_fail++; $display("FAIL glitch_low reached=%0d badcycles=%0d idle=%0d want 1 0 0", ok, bad, idle); end
      drops = 0; jumps = 0; saw_origin = 1'b0;
      prev_idx = 32'(px_y) * HT + 32'(px_x);
      for (int c = 0; c < int'(FRAME_CLK); c++) begin
         @(negedge clk);
         n_cmp++;
         if (obs !== model_vec()) begin n_fail++; $display("FAIL glitch_vec c=%0d got=%h want=%h", c, obs, model_vec()); end
         if (running !== 1'b1) drops++;
         idx = 32'(px_y) * HT + 32'(px_x);
         if (idx != prev_idx) begin
            if (idx != (prev_idx + 1) % FRAME_PIX) jumps++;
            if (idx == 0) saw_origin = 1'b1;
            prev_idx = idx;
         end
      end
      n_cmp++;
      if (drops != 0 || jumps != 0 || !saw_origin)
         begin n_fail++; $display("FAIL glitch_continuity drops=%0d jumps=%0d origin=%0d want 0 0 1", drops, jumps, saw_origin); end
   endtask

   task automatic test_eof_drop();
      bit ok, fell;
      int bad, idle, cnt;
      restart();
      run_to(HT - 1, VT - 1, ok, bad, idle);
      repeat (DIV - 1) @(negedge clk);
      n_cmp++;
      if (!ok || bad != 0 || pix_en !== 1'b1) begin n_fail++; $display("FAIL eof_align reached=%0d badcycles=%0d pix_en=%b want 1 0 1", ok, bad, pix_en); end
      en = 1'b0;
      cnt = 0; fell = 1'b0;
      for (int c = 0; c < int'(FRAME_CLK) + 16 && !fell; c++) begin
         @(negedge clk);
         n_cmp++;
         if (obs !== model_vec()) begin n_fail++; $display("FAIL eof_vec c=%0d got=%h want=%h", c, obs, model_vec()); end
         if (running === 1'b1) cnt++; else fell = 1'b1;
      end
      n_cmp++;
      if (!fell || cnt != int'(FRAME_CLK)) begin n_fail++; $display("FAIL eof_drain_len fell=%0d clks=%0d want 1 %0d", fell, cnt, FRAME_CLK); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int bad, idle;
      restart();
      run_to(15, 7, ok, bad, idle);
      n_cmp++;
      if (!ok || bad != 0) begin n_fail++; $display("FAIL rst_align reached=%0d badcycles=%0d want 1 0", ok, bad); end
      #2 clr_n = 1'b0;
      #1;
      n_cmp++;
      if (obs !== RST_VEC) begin n_fail++; $display("FAIL async_reset got=%h want=%h", obs, RST_VEC); end
      @(negedge clk);
      clr_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (running !== 1'b1 || px_x !== 10'd0 || px_y !== 10'd0 || video_on !== 1'b1)
         begin n_fail++; $display("FAIL restart_origin run=%b x=%0d y=%0d vid=%b want 1 0 0 1", running, px_x, px_y, video_on); end
      run_to(0, 2, ok, bad, idle);
      n_cmp++;
      if (!ok || bad != 0) begin n_fail++; $display("FAIL restart_run reached=%0d badcycles=%0d want 1 0", ok, bad); end
   endtask

   task automatic test_random();
      int unsigned len;
      for (int s = 0; s < 14; s++) begin
         en  = 1'($urandom_range(0, 1));
         len = ($urandom_range(0, 3) == 0) ? $urandom_range(FRAME_CLK, 2 * FRAME_CLK) : $urandom_range(1, 400);
         if ($urandom_range(0, 7) == 0) begin
            #2 clr_n = 1'b0;
            #1;
            n_cmp++;
            if (obs !== RST_VEC) begin n_fail++; $display("FAIL rand_reset s=%0d got=%h want=%h", s, obs, RST_VEC); end
            @(negedge clk);
            clr_n = 1'b1;
         end
         for (int unsigned c = 0; c < len; c++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== model_vec()) begin n_fail++; $display("FAIL rand_vec s=%0d c=%0d got=%h want=%h", s, c, obs, model_vec()); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_start();
      test_full_frame();
      test_drain();
      test_glitch();
      test_eof_drop();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog time=%0t limit=2000000", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
